sgd_server_send: RTL and testbench
==================================

SGD_SERVER_SEND -- requirements
Module: sgd_server_send

Interface
REQ-001 Parameters: none; ENGINE_NUM, WORKER_NUM and NUM_OF_BANKS come from sgd_defines.vh.
REQ-002 clk  in  1  single clock; every register is updated on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 control_reg  in  [15:0][31:0]  configuration:
- word[i] (i<WORKER_NUM): worker i IP address.
- word[8][3:0]: active worker count, N.
- word[9][0]: enable.
REQ-005 session_id  in  [WORKER_NUM-1:0][15:0]  TCP session of each worker.
REQ-006 s_model_data  in  [ENGINE_NUM-1:0][NUM_OF_BANKS-1:0][31:0]  one model-update bundle, one 256-bit word per engine.
REQ-007 s_model_valid  in  1  s_model_data holds a bundle.
REQ-008 s_model_ready  out  1  bundle accepted when valid and ready are both high.
REQ-009 m_axis_tx_metadata  axis_meta.master  data[15:0]=session, data[31:16]=byte length.
REQ-010 s_axis_tx_status  axis_meta.slave  data[15:0]=session, data[31:30]=error code.
REQ-011 m_axis_tx_data  axi_stream.master  512-bit data, keep, last.
REQ-012 bundles_sent  out  32  count of bundles delivered to all N workers.
REQ-013 tx_errors  out  32  count of status responses with a nonzero error code.

Function
REQ-014 FSM states: IDLE, SEND_META, WAIT_STATUS, SEND_DATA, NEXT, BACKOFF.
REQ-015 s_model_ready is high only in IDLE while enable=1 and N!=0.
- On handshake: latch the bundle, set worker index w=0, go to SEND_META.
REQ-016 SEND_META: tx_metadata.valid=1 with session_id[w] and length = ENGINE_NUM*64.
- Hold valid and data stable until ready.
- On handshake go to WAIT_STATUS.
REQ-017 WAIT_STATUS: tx_status.ready=1.
- Error code 0: go to SEND_DATA.
- Error code nonzero: increment tx_errors, go to BACKOFF.
REQ-018 BACKOFF: wait exactly 8 cycles, then return to SEND_META for the same w.
- No retry limit.
REQ-019 SEND_DATA: send ENGINE_NUM beats, beat k carrying engine k in data[255:0].
- data[511:256]=0; keep=all ones; last high only on beat ENGINE_NUM-1.
- Beat index advances only on valid&ready.
- valid, data and last are stable while ready is low.
REQ-020 After the last beat go to NEXT.
- NEXT: if w==N-1, increment bundles_sent and go to IDLE; otherwise w=w+1 and go to SEND_META.
REQ-021 Minimum latency from bundle accept to first tx_metadata.valid: 1 cycle.
REQ-022 Control_reg and session_id are sampled at each SEND_META entry.
- Enable deasserting mid-bundle does not abort it.
REQ-023 N greater than WORKER_NUM is clamped to WORKER_NUM.
REQ-024 Both counters wrap at 2^32 without saturating.

Reset
REQ-025 With rst_n=0 at a clock edge:
- state becomes IDLE; w=0; beat index=0; counters=0.
- All valid outputs and all ready outputs become 0 at the next edge, including reset mid-transfer.
REQ-026 Latched bundle contents are don't-care after reset.

Structure
REQ-027 FSM state enum and the metadata/status field offsets go in the shared sgd package.
REQ-028 ENGINE_NUM and WORKER_NUM are used only from sgd_defines.vh.
REQ-029 Single flat module; no sub-module.

Verification
REQ-030 N=2, ENGINE_NUM=2, tx ready always high, bundle of incrementing words:
- Metadata sessions are 0x10 then 0x11, length 128 each.
- 4 data beats, with last on beats 2 and 4.
- bundles_sent=1.
REQ-031 Status error=1 on the first response:
- tx_errors=1.
- Metadata is reissued exactly 8 cycles after the status handshake, with the same session.
REQ-032 tx_data.ready toggled 0/1 every cycle:
- No beat is lost or duplicated.
- Data is held stable during stalls.
REQ-033 rst_n pulsed low during beat 1 of worker 0:
- Next cycle all valid outputs are 0 and state is IDLE.
- A new bundle then transmits correctly.
REQ-034 Enable=0 with s_model_valid high: s_model_ready stays 0 for 100 cycles and nothing is transmitted.
REQ-035 N=0: s_model_ready stays 0 for 100 cycles and nothing is transmitted.

Source files
------------

// File: rtl/sgd_pkg.sv
// Shared SGD definitions: build sizes, FSM state codes and tx metadata/status layouts.
package sgd_pkg;

  localparam int unsigned ENGINE_NUM     = 2;
  localparam int unsigned WORKER_NUM     = 4;
  localparam int unsigned NUM_OF_BANKS   = 8;

  localparam int unsigned BANK_W         = 32;
  localparam int unsigned ENGINE_W       = NUM_OF_BANKS * BANK_W;
  localparam int unsigned TX_DATA_W      = 512;
  localparam int unsigned TX_KEEP_W      = TX_DATA_W / 8;
  localparam int unsigned META_W         = 32;
  localparam int unsigned WIDX_W         = (WORKER_NUM > 1) ? $clog2(WORKER_NUM) : 1;
  localparam int unsigned BEAT_W         = (ENGINE_NUM > 1) ? $clog2(ENGINE_NUM) : 1;
  localparam int unsigned BACKOFF_CYCLES = 8;
  localparam int unsigned BOFF_W         = $clog2(BACKOFF_CYCLES);

  // Each engine contributes one 64-byte beat to the payload.
  localparam logic [15:0] TX_BYTE_LEN    = 16'(ENGINE_NUM * 64);

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_SEND_META   = 3'd1;
  localparam logic [2:0] ST_WAIT_STATUS = 3'd2;
  localparam logic [2:0] ST_SEND_DATA   = 3'd3;
  localparam logic [2:0] ST_NEXT        = 3'd4;
  localparam logic [2:0] ST_BACKOFF     = 3'd5;

  // tx metadata word: session in [15:0], byte length in [31:16]
  typedef struct packed {
    logic [15:0] len;
    logic [15:0] session;
  } tx_meta_t;

  // tx status word: session in [15:0], error code in [31:30]
  typedef struct packed {
    logic [1:0]  err;
    logic [13:0] rsvd;
    logic [15:0] session;
  } tx_status_t;

  // Active worker count, clamped to the number of session slots.
  function automatic logic [3:0] clamp_workers(input logic [3:0] n);
    return (32'(n) > WORKER_NUM) ? 4'(WORKER_NUM) : n;
  endfunction

endpackage

// File: rtl/sgd_server_send.sv
// Sends one accepted model-update bundle to each active worker over the TCP tx path.
module sgd_server_send
  import sgd_pkg::*;
(
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [15:0][31:0]                             control_reg,
  input  logic [WORKER_NUM-1:0][15:0]                   session_id,
  input  logic [ENGINE_NUM-1:0][NUM_OF_BANKS-1:0][31:0] s_model_data,
  input  logic                                          s_model_valid,
  output logic                                          s_model_ready,
  output logic                                          m_axis_tx_metadata_valid,
  input  logic                                          m_axis_tx_metadata_ready,
  output logic [META_W-1:0]                             m_axis_tx_metadata_data,
  input  logic                                          s_axis_tx_status_valid,
  output logic                                          s_axis_tx_status_ready,
  input  logic [META_W-1:0]                             s_axis_tx_status_data,
  output logic                                          m_axis_tx_data_valid,
  input  logic                                          m_axis_tx_data_ready,
  output logic [TX_DATA_W-1:0]                          m_axis_tx_data_data,
  output logic [TX_KEEP_W-1:0]                          m_axis_tx_data_keep,
  output logic                                          m_axis_tx_data_last,
  output logic [31:0]                                   bundles_sent,
  output logic [31:0]                                   tx_errors
);

  localparam int unsigned PAD_W = TX_DATA_W - ENGINE_W;

  logic [2:0]                           state_q, state_n;
  logic [WIDX_W-1:0]                    w_q, w_n;
  logic [BEAT_W-1:0]                    beat_q, beat_n;
  logic [BOFF_W-1:0]                    boff_q, boff_n;
  logic [3:0]                           n_q, n_n;
  logic [31:0]                          bundles_q, bundles_n;
  logic [31:0]                          errors_q, errors_n;
  logic                                 model_ready_q, model_ready_n;
  logic                                 meta_valid_q, meta_valid_n;
  tx_meta_t                             meta_q, meta_n;
  logic                                 status_ready_q, status_ready_n;
  logic                                 data_valid_q, data_valid_n;
  logic [TX_DATA_W-1:0]                 data_q, data_n;
  logic [TX_KEEP_W-1:0]                 keep_q, keep_n;
  logic                                 last_q, last_n;
  logic [ENGINE_NUM-1:0][ENGINE_W-1:0]  bundle_q;
  logic                                 accept_c;
  logic                                 meta_entry_c;
  tx_status_t                           status;
  logic                                 unused_ok;

  assign status = s_axis_tx_status_data;

  // Configuration and status fields this block does not consume.
  assign unused_ok = ^{control_reg[15:10], control_reg[9][31:1], control_reg[8][31:4],
                       control_reg[7:0], status.rsvd, status.session};

  // Next-state, counters and next registered-output values.
  always_comb begin
    state_n   = state_q;
    w_n       = w_q;
    beat_n    = beat_q;
    boff_n    = boff_q;
    n_n       = n_q;
    bundles_n = bundles_q;
    errors_n  = errors_q;
    accept_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s_model_valid && model_ready_q) begin
          accept_c = 1'b1;
          w_n      = '0;
          state_n  = ST_SEND_META;
        end
      end
      ST_SEND_META: begin
        if (meta_valid_q && m_axis_tx_metadata_ready) state_n = ST_WAIT_STATUS;
      end
      ST_WAIT_STATUS: begin
        if (s_axis_tx_status_valid && status_ready_q) begin
          if (status.err != 2'd0) begin
            errors_n = errors_q + 32'd1;
            boff_n   = '0;
            state_n  = ST_BACKOFF;
          end else begin
            beat_n  = '0;
            state_n = ST_SEND_DATA;
          end
        end
      end
      ST_BACKOFF: begin
        if (boff_q == BOFF_W'(BACKOFF_CYCLES - 1)) state_n = ST_SEND_META;
        else                                        boff_n  = boff_q + BOFF_W'(1);
      end
      ST_SEND_DATA: begin
        if (data_valid_q && m_axis_tx_data_ready) begin
          if (beat_q == BEAT_W'(ENGINE_NUM - 1)) begin
            beat_n  = '0;
            state_n = ST_NEXT;
          end else begin
            beat_n = beat_q + BEAT_W'(1);
          end
        end
      end
      ST_NEXT: begin
        // ">=" also terminates cleanly if N was rewritten to 0 mid-bundle.
        if ((5'(w_q) + 5'd1) >= 5'(n_q)) begin
          bundles_n = bundles_q + 32'd1;
          w_n       = '0;
          state_n   = ST_IDLE;
        end else begin
          w_n     = w_q + WIDX_W'(1);
          state_n = ST_SEND_META;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    meta_entry_c = (state_n == ST_SEND_META) && (state_q != ST_SEND_META);
    meta_n       = meta_q;
    if (meta_entry_c) begin
      n_n            = clamp_workers(control_reg[8][3:0]);
      meta_n.len     = TX_BYTE_LEN;
      meta_n.session = session_id[w_n];
    end

    model_ready_n  = (state_n == ST_IDLE) && control_reg[9][0] && (control_reg[8][3:0] != 4'd0);
    meta_valid_n   = (state_n == ST_SEND_META);
    status_ready_n = (state_n == ST_WAIT_STATUS);
    data_valid_n   = (state_n == ST_SEND_DATA);
    data_n         = data_valid_n ? {{PAD_W{1'b0}}, bundle_q[beat_n]} : '0;
    keep_n         = data_valid_n ? '1 : '0;
    last_n         = data_valid_n && (beat_n == BEAT_W'(ENGINE_NUM - 1));
  end

  // State, indices, counters and all outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      w_q            <= '0;
      beat_q         <= '0;
      boff_q         <= '0;
      n_q            <= '0;
      bundles_q      <= '0;
      errors_q       <= '0;
      model_ready_q  <= 1'b0;
      meta_valid_q   <= 1'b0;
      meta_q         <= '0;
      status_ready_q <= 1'b0;
      data_valid_q   <= 1'b0;
      data_q         <= '0;
      keep_q         <= '0;
      last_q         <= 1'b0;
    end else begin
      state_q        <= state_n;
      w_q            <= w_n;
      beat_q         <= beat_n;
      boff_q         <= boff_n;
      n_q            <= n_n;
      bundles_q      <= bundles_n;
      errors_q       <= errors_n;
      model_ready_q  <= model_ready_n;
      meta_valid_q   <= meta_valid_n;
      meta_q         <= meta_n;
      status_ready_q <= status_ready_n;
      data_valid_q   <= data_valid_n;
      data_q         <= data_n;
      keep_q         <= keep_n;
      last_q         <= last_n;
    end
  end

  // Bundle payload capture; contents are irrelevant until the next accept.
  always_ff @(posedge clk) begin
    if (accept_c) bundle_q <= s_model_data;
  end

  assign s_model_ready            = model_ready_q;
  assign m_axis_tx_metadata_valid = meta_valid_q;
  assign m_axis_tx_metadata_data  = meta_q;
  assign s_axis_tx_status_ready   = status_ready_q;
  assign m_axis_tx_data_valid     = data_valid_q;
  assign m_axis_tx_data_data      = data_q;
  assign m_axis_tx_data_keep      = keep_q;
  assign m_axis_tx_data_last      = last_q;
  assign bundles_sent             = bundles_q;
  assign tx_errors                = errors_q;

endmodule

// File: tb/tb_sgd_server_send.sv
// Bench for sgd_server_send: table rows, a reset-mid-transfer sequence and random bundles
// checked against a transaction-level model of the expected metadata/beat streams.
`timescale 1ns/1ps
module tb_sgd_server_send;
  import sgd_pkg::*;

  logic                                          clk = 1'b0;
  logic                                          rst_n;
  logic [15:0][31:0]                             control_reg;
  logic [WORKER_NUM-1:0][15:0]                   session_id;
  logic [ENGINE_NUM-1:0][NUM_OF_BANKS-1:0][31:0] s_model_data;
  logic                                          s_model_valid;
  logic                                          s_model_ready;
  logic                                          mv, mr;
  logic [31:0]                                   md;
  logic                                          sv, sr;
  logic [31:0]                                   sd;
  logic                                          dv, dr;
  logic [TX_DATA_W-1:0]                          dd;
  logic [TX_KEEP_W-1:0]                          dk;
  logic                                          dl;
  logic [31:0]                                   bundles_sent, tx_errors;

  always #5 clk = ~clk;

  sgd_server_send dut (
    .clk(clk), .rst_n(rst_n), .control_reg(control_reg), .session_id(session_id),
    .s_model_data(s_model_data), .s_model_valid(s_model_valid), .s_model_ready(s_model_ready),
    .m_axis_tx_metadata_valid(mv), .m_axis_tx_metadata_ready(mr), .m_axis_tx_metadata_data(md),
    .s_axis_tx_status_valid(sv), .s_axis_tx_status_ready(sr), .s_axis_tx_status_data(sd),
    .m_axis_tx_data_valid(dv), .m_axis_tx_data_ready(dr), .m_axis_tx_data_data(dd),
    .m_axis_tx_data_keep(dk), .m_axis_tx_data_last(dl),
    .bundles_sent(bundles_sent), .tx_errors(tx_errors)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int err_plan[$];
  int drv_code;
  logic [ENGINE_NUM-1:0][NUM_OF_BANKS-1:0][31:0] bundle;

  // monitor state
  logic [31:0]  obs_meta[$];
  logic [512:0] obs_beat[$];
  bit           meta_hs_f, st_hs_f;
  logic [15:0]  hs_session;
  int acc_cnt, acc_cyc, ready_seen, stall_viol, keep_viol, gap_viol, gaps_seen, lat, err_cyc;
  bit lat_pending, gap_pending;
  logic prev_mv, prev_mr, prev_dv, prev_dr, prev_dl;
  logic [31:0] prev_md;
  logic [TX_DATA_W-1:0] prev_dd;

  int exp_bundles = 0;
  int exp_errors = 0;

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [512:0] act, input logic [512:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Observe handshakes, stability and timing mid-cycle.
  initial begin
    prev_mv = 0; prev_mr = 0; prev_dv = 0; prev_dr = 0; prev_dl = 0; prev_md = '0; prev_dd = '0;
    forever begin
      @(negedge clk);
      meta_hs_f  = mv && mr;
      st_hs_f    = sv && sr;
      hs_session = md[15:0];
      if (s_model_ready) ready_seen++;
      if (s_model_valid && s_model_ready) begin
        acc_cnt++; acc_cyc = cyc; lat_pending = 1;
      end
      if (mv && !prev_mv) begin
        if (lat_pending) begin lat = cyc - acc_cyc; lat_pending = 0; end
        if (gap_pending) begin
          gaps_seen++;
          // status handshake lands on the edge after err_cyc; reissue must come 8 edges later
          if (cyc - (err_cyc + 1) != 8) gap_viol++;
          gap_pending = 0;
        end
      end
      if (sv && sr && sd[31:30] != 2'd0) begin err_cyc = cyc; gap_pending = 1; end
      if (mv && mr) obs_meta.push_back(md);
      if (dv && dr) begin
        obs_beat.push_back({dl, dd});
        if (dk !== '1) keep_viol++;
      end
      if (prev_dv && !prev_dr && (!dv || dd !== prev_dd || dl !== prev_dl)) stall_viol++;
      if (prev_mv && !prev_mr && (!mv || md !== prev_md)) stall_viol++;
      prev_mv = mv; prev_mr = mr; prev_md = md;
      prev_dv = dv; prev_dr = dr; prev_dd = dd; prev_dl = dl;
    end
  end

  // Ready generators and status responder, driven just after each edge.
  initial begin
    mr = 0; dr = 0; sv = 0; sd = '0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       begin mr = 1'b1; dr = 1'b1; end
        1:       begin mr = ~mr;  dr = ~dr;  end
        default: begin mr = 1'($urandom); dr = 1'($urandom); end
      endcase
      if (!rst_n) sv = 1'b0;
      else begin
        if (st_hs_f) sv = 1'b0;
        if (meta_hs_f) begin
          drv_code = (err_plan.size() > 0) ? err_plan.pop_front() : 0;
          sv = 1'b1;
          sd = {2'(drv_code), 14'd0, hs_session};
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_monitor();
    obs_meta.delete(); obs_beat.delete();
    acc_cnt = 0; ready_seen = 0; stall_viol = 0; keep_viol = 0;
    gap_viol = 0; gaps_seen = 0; lat = -1; lat_pending = 0; gap_pending = 0;
  endtask

  // Offer one bundle and compare the whole transmission against the model.
  task automatic run_bundle(input logic [3:0] n_raw, input logic en, input int mode, input int exp_acc);
    int n, code, exp_gaps, t, m;
    int plan_copy[$];
    logic [31:0]  exp_meta[$];
    logic [512:0] exp_beat[$];
    n = int'(n_raw);
    if (n > int'(WORKER_NUM)) n = int'(WORKER_NUM);
    plan_copy = err_plan;
    exp_gaps = 0;
    if (exp_acc != 0) begin
      for (int w = 0; w < n; w++) begin
        do begin
          exp_meta.push_back({16'(ENGINE_NUM * 64), session_id[w]});
          code = (plan_copy.size() > 0) ? plan_copy.pop_front() : 0;
          if (code != 0) begin exp_errors++; exp_gaps++; end
        end while (code != 0);
        for (int e = 0; e < ENGINE_NUM; e++)
          exp_beat.push_back({1'(e == ENGINE_NUM - 1), 256'd0, bundle[e]});
      end
    end

    rdy_mode = mode;
    control_reg[8] = 32'(n_raw);
    control_reg[9] = 32'(en);
    s_model_data = bundle;
    step(2);
    clear_monitor();
    s_model_valid = 1'b1;

    if (exp_acc == 0) begin
      step(100);
      s_model_valid = 1'b0;
      chk_int("reject_ready_seen", ready_seen, 0);
      chk_int("reject_accepts", acc_cnt, 0);
      chk_int("reject_meta_cnt", obs_meta.size(), 0);
      chk_int("reject_beat_cnt", obs_beat.size(), 0);
      chk_int("reject_bundles", int'(bundles_sent), exp_bundles);
      return;
    end

    t = 0;
    while (acc_cnt == 0 && t < 50) begin step(1); t++; end
    s_model_valid = 1'b0;
    chk_int("accepted", acc_cnt, exp_acc);
    if (acc_cnt == 0) return;
    exp_bundles++;
    t = 0;
    while (bundles_sent != 32'(exp_bundles) && t < 4000) begin step(1); t++; end
    chk_int("bundle_done_in_time", (t < 4000) ? 1 : 0, 1);
    step(2);

    chk_int("meta_latency", lat, 1);
    chk_int("meta_count", obs_meta.size(), exp_meta.size());
    m = (obs_meta.size() < exp_meta.size()) ? obs_meta.size() : exp_meta.size();
    for (int i = 0; i < m; i++) chk_vec($sformatf("meta[%0d]", i), 513'(obs_meta[i]), 513'(exp_meta[i]));
    chk_int("beat_count", obs_beat.size(), exp_beat.size());
    m = (obs_beat.size() < exp_beat.size()) ? obs_beat.size() : exp_beat.size();
    for (int i = 0; i < m; i++) chk_vec($sformatf("beat[%0d]", i), obs_beat[i], exp_beat[i]);
    chk_int("bundles_sent", int'(bundles_sent), exp_bundles);
    chk_int("tx_errors", int'(tx_errors), exp_errors);
    chk_int("stall_stability", stall_viol, 0);
    chk_int("keep_all_ones", keep_viol, 0);
    chk_int("backoff_count", gaps_seen, exp_gaps);
    chk_int("backoff_8_cycles", gap_viol, 0);
  endtask

  typedef struct {
    logic [3:0] n_raw;
    logic       en;
    int         mode;      // 0 ready high, 1 toggle, 2 random
    int         nerr;      // leading error responses
    bit         inc_data;
    int         exp_acc;
  } vec_t;

  vec_t tbl[7];
  int   t;
  logic [3:0] rn;
  logic ren;

  initial begin
    rst_n = 1'b0;
    control_reg = '0;
    s_model_data = '0;
    s_model_valid = 1'b0;
    for (int i = 0; i < int'(WORKER_NUM); i++) session_id[i] = 16'(16'h10 + i);
    step(3);
    chk_int("rst_model_ready", int'(s_model_ready), 0);
    chk_int("rst_meta_valid", int'(mv), 0);
    chk_int("rst_data_valid", int'(dv), 0);
    chk_int("rst_status_ready", int'(sr), 0);
    chk_int("rst_bundles", int'(bundles_sent), 0);
    chk_int("rst_errors", int'(tx_errors), 0);
    rst_n = 1'b1;
    step(1);

    tbl[0] = '{4'd2, 1'b1, 0, 0, 1'b1, 1};
    tbl[1] = '{4'd2, 1'b1, 0, 1, 1'b1, 1};
    tbl[2] = '{4'd2, 1'b1, 1, 0, 1'b0, 1};
    tbl[3] = '{4'd2, 1'b0, 0, 0, 1'b0, 0};
    tbl[4] = '{4'd0, 1'b1, 0, 0, 1'b0, 0};
    tbl[5] = '{4'd9, 1'b1, 2, 2, 1'b0, 1};
    tbl[6] = '{4'd1, 1'b1, 1, 3, 1'b1, 1};

    for (int r = 0; r < 7; r++) begin
      for (int e = 0; e < int'(ENGINE_NUM); e++)
        for (int b = 0; b < int'(NUM_OF_BANKS); b++)
          bundle[e][b] = tbl[r].inc_data ? 32'(e * int'(NUM_OF_BANKS) + b + 1) : $urandom;
      err_plan.delete();
      for (int k = 0; k < tbl[r].nerr; k++) err_plan.push_back((r == 1) ? 1 : int'($urandom_range(1, 3)));
      run_bundle(tbl[r].n_raw, tbl[r].en, tbl[r].mode, tbl[r].exp_acc);
    end

    // Reset while the first data beat of worker 0 is on the bus.
    err_plan.delete();
    for (int e = 0; e < int'(ENGINE_NUM); e++)
      for (int b = 0; b < int'(NUM_OF_BANKS); b++) bundle[e][b] = $urandom;
    rdy_mode = 0;
    control_reg[8] = 32'd2;
    control_reg[9] = 32'd1;
    s_model_data = bundle;
    step(2);
    clear_monitor();
    s_model_valid = 1'b1;
    t = 0;
    while (dv !== 1'b1 && t < 100) begin
      step(1);
      if (acc_cnt > 0) s_model_valid = 1'b0;
      t++;
    end
    s_model_valid = 1'b0;
    chk_int("reset_seq_reached_beat", int'(dv), 1);
    rst_n = 1'b0;
    step(1);
    chk_int("mid_rst_meta_valid", int'(mv), 0);
    chk_int("mid_rst_data_valid", int'(dv), 0);
    chk_int("mid_rst_status_ready", int'(sr), 0);
    chk_int("mid_rst_model_ready", int'(s_model_ready), 0);
    chk_int("mid_rst_bundles", int'(bundles_sent), 0);
    chk_int("mid_rst_errors", int'(tx_errors), 0);
    rst_n = 1'b1;
    exp_bundles = 0;
    exp_errors = 0;
    step(1);
    chk_int("post_rst_idle_ready", int'(s_model_ready), 1);
    run_bundle(4'd2, 1'b1, 1, 1);

    // Randomized bundles: random N (incl. 0 and over-range), enable, readiness and errors.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < int'(WORKER_NUM); i++) session_id[i] = 16'($urandom);
      for (int e = 0; e < int'(ENGINE_NUM); e++)
        for (int b = 0; b < int'(NUM_OF_BANKS); b++) bundle[e][b] = $urandom;
      err_plan.delete();
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) err_plan.push_back(int'($urandom_range(0, 3)));
      rn  = 4'($urandom_range(0, 15));
      ren = ($urandom_range(0, 7) != 0);
      run_bundle(rn, ren, int'($urandom_range(0, 2)), (ren && rn != 4'd0) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
